// File: rtl/pdecoder4_buf.sv
// pdecoder4_buf: FIFO-buffered 2-to-4 decoder with valid/ready on both sides and a wrapping pop counter.
module pdecoder4_buf #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             y0,
  input  logic             y1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       d,
  output logic             full,
  output logic [CNT_W-1:0] dec_cnt
);
  localparam int AW = $clog2(DEPTH);
  logic [3:0]       mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]      occ_q, occ_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push, pop;
  always_comb begin
    full      = occ_q == (AW+1)'(DEPTH);
    in_ready  = rst_n & ~full;
    out_valid = occ_q != '0;
    d         = out_valid ? mem_q[rd_q] : 4'b0000;
    dec_cnt   = cnt_q;
    push      = in_valid & in_ready;
    pop       = out_valid & out_ready;
    wr_d      = push ? wr_q + AW'(1) : wr_q;
    rd_d      = pop ? rd_q + AW'(1) : rd_q;
    cnt_d     = pop ? cnt_q + CNT_W'(1) : cnt_q;
    occ_d     = occ_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  // Codes are stored already decoded so the read side is a plain mux.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= 4'b0001 << {y0, y1};
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      occ_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      occ_q <= occ_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_pdecoder4_buf.sv
// tb_pdecoder4_buf: directed and random checks of pdecoder4_buf against a queue-based reference model.
module tb_pdecoder4_buf;
  localparam int DEPTH = 2;
  localparam int CNT_W = 2;
  logic clk = 0, rst_n = 0, in_valid = 0, y0 = 0, y1 = 0, out_ready = 0;
  logic in_ready, out_valid, full;
  logic [3:0] d;
  logic [CNT_W-1:0] dec_cnt;
  int n_cmp = 0, n_err = 0;
  int q[$];
  int m_cnt = 0;

  pdecoder4_buf #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .y0(y0), .y1(y1), .out_valid(out_valid), .out_ready(out_ready),
    .d(d), .full(full), .dec_cnt(dec_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle: set inputs, check outputs against the model, clock, update the model.
  task automatic step(input logic r, input logic iv, input int code, input logic ordy, input string tag);
    logic can_push, can_pop;
    rst_n = r; in_valid = iv; y0 = code[1]; y1 = code[0]; out_ready = ordy;
    #1;
    can_push = r && q.size() < DEPTH;
    can_pop  = q.size() > 0;
    chk({tag, ".in_ready"}, {7'd0, in_ready}, {7'd0, can_push});
    chk({tag, ".out_valid"}, {7'd0, out_valid}, {7'd0, can_pop});
    chk({tag, ".d"}, {4'd0, d}, can_pop ? 8'(1 << q[0]) : 8'd0);
    chk({tag, ".full"}, {7'd0, full}, {7'd0, q.size() == DEPTH});
    chk({tag, ".dec_cnt"}, {6'd0, dec_cnt}, 8'(m_cnt));
    @(posedge clk);
    if (!r) begin
      q.delete();
      m_cnt = 0;
    end else begin
      if (can_pop && ordy) begin
        void'(q.pop_front());
        m_cnt = (m_cnt + 1) % (1 << CNT_W);
      end
      if (can_push && iv) q.push_back(code);
    end
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    step(0, 1, 3, 1, "rst0");
    step(0, 1, 2, 1, "rst1");
    step(1, 0, 0, 1, "idle");
    step(1, 1, 0, 1, "map00");
    step(1, 1, 1, 1, "map01");
    step(1, 1, 2, 1, "map10");
    step(1, 1, 3, 1, "map11");
    step(1, 0, 0, 1, "mapdrain");
    step(1, 0, 0, 1, "mapdone");
    step(1, 1, 3, 0, "bp11");
    step(1, 1, 2, 0, "bp10");
    step(1, 1, 1, 0, "bpfull");
    step(1, 1, 1, 0, "bphold");
    step(1, 0, 0, 1, "bppop1");
    step(1, 0, 0, 1, "bppop2");
    step(1, 0, 0, 1, "bpempty");
    step(1, 1, 2, 0, "pp_fill");
    step(1, 1, 1, 1, "pp_both");
    step(1, 0, 0, 0, "pp_after");
    step(1, 0, 0, 1, "pp_pop");
    for (int i = 0; i < 5; i++) step(1, 1, i % 4, 1, "wrap");
    step(1, 0, 0, 1, "wrapdrain");
    step(1, 1, 1, 0, "mid_a");
    step(1, 1, 3, 0, "mid_b");
    step(0, 1, 2, 1, "mid_rst");
    step(1, 0, 0, 1, "mid_after");
    step(1, 0, 0, 1, "mid_after2");
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 29) != 0, 1'($urandom), int'($urandom_range(0, 3)),
           1'($urandom), "rand");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
